// File: rtl/vram_write_scheduler_pkg.sv
// Shared types for the VRAM write scheduler.
// FSM state encodings and default map geometry.
package vram_write_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_CLEAR
  } state_e;

  localparam int unsigned DEF_ADDR_W = 13;
  localparam int unsigned DEF_DATA_W = 8;

endpackage

// File: rtl/vram_write_scheduler_sync_fifo.sv
// Synchronous FIFO with registered occupancy level.
// Head entry is presented combinationally on dout.
module sync_fifo #(
  parameter int W     = 21,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == DEPTH[PW:0]);
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rp];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      level <= level
             + {{PW{1'b0}}, do_push}
             - {{PW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

endmodule

// File: rtl/vram_write_scheduler.sv
// Single-port map RAM owner: pixel fetch first,
// host FIFO writes and clear fill in free cycles.
module vram_write_scheduler
  import vram_write_scheduler_pkg::*;
#(
  parameter int                ADDR_W     = DEF_ADDR_W,
  parameter int                DATA_W     = DEF_DATA_W,
  parameter int                FIFO_DEPTH = 16,
  parameter bit                BLANK_ONLY = 1'b1,
  parameter logic [DATA_W-1:0] CLEAR_DATA = 'h20
) (
  input  logic                        i_pix_clk,
  input  logic                        i_reset,
  input  logic                        i_horz_blank,
  input  logic                        i_vert_blank,
  input  logic                        i_rd_req,
  input  logic [ADDR_W-1:0]           i_rd_addr,
  output logic                        o_rd_valid,
  output logic [DATA_W-1:0]           o_rd_data,
  input  logic                        i_wr_valid,
  input  logic [ADDR_W-1:0]           i_wr_addr,
  input  logic [DATA_W-1:0]           i_wr_data,
  output logic                        o_wr_ready,
  input  logic                        i_clear_start,
  output logic                        o_clear_busy,
  output logic [$clog2(FIFO_DEPTH):0] o_fifo_level,
  output logic [ADDR_W-1:0]           o_ram_addr,
  output logic [DATA_W-1:0]           o_ram_wdata,
  output logic                        o_ram_we,
  input  logic [DATA_W-1:0]           i_ram_rdata
);

  localparam int FW = ADDR_W + DATA_W;

  state_e              state;
  state_e              state_n;
  logic [ADDR_W-1:0]   clr_cnt;
  logic                rd_valid_q;
  logic                slot;
  logic                push;
  logic                pop;
  logic                clr_we;
  logic                fifo_full;
  logic                fifo_empty;
  logic [FW-1:0]       head;

  sync_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (i_pix_clk),
    .rst   (i_reset),
    .push  (push),
    .pop   (pop),
    .din   ({i_wr_addr, i_wr_data}),
    .dout  (head),
    .level (o_fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign o_wr_ready   = !fifo_full;
  assign push         = i_wr_valid && o_wr_ready;
  assign o_clear_busy = (state == ST_CLEAR);
  assign o_rd_valid   = rd_valid_q;
  assign o_rd_data    = rd_valid_q ? i_ram_rdata : '0;

  assign slot = !i_rd_req &&
                (!BLANK_ONLY || i_horz_blank || i_vert_blank);

  always_comb begin
    o_ram_addr  = '0;
    o_ram_wdata = '0;
    o_ram_we    = 1'b0;
    pop         = 1'b0;
    clr_we      = 1'b0;
    unique case (1'b1)
      i_rd_req: o_ram_addr = i_rd_addr;
      (slot && state == ST_CLEAR): begin
        o_ram_addr  = clr_cnt;
        o_ram_wdata = CLEAR_DATA;
        o_ram_we    = 1'b1;
        clr_we      = 1'b1;
      end
      (slot && state == ST_DRAIN && !fifo_empty): begin
        o_ram_addr  = head[FW-1:DATA_W];
        o_ram_wdata = head[DATA_W-1:0];
        o_ram_we    = 1'b1;
        pop         = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE: begin
        if (i_clear_start) state_n = ST_CLEAR;
        else if (push)     state_n = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (i_clear_start)
          state_n = ST_CLEAR;
        else if (pop && !push && o_fifo_level == 1)
          state_n = ST_IDLE;
      end
      ST_CLEAR: begin
        // Leave only after the top address has been filled
        if (clr_we && (&clr_cnt))
          state_n = (!fifo_empty || push) ? ST_DRAIN : ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_pix_clk or posedge i_reset) begin
    if (i_reset) begin
      state      <= ST_IDLE;
      clr_cnt    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state      <= state_n;
      rd_valid_q <= i_rd_req;
      if (clr_we) clr_cnt <= clr_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_vram_write_scheduler.sv
// Scoreboard bench for vram_write_scheduler.
// Directed stimulus; a negedge monitor checks RAM writes and fetch data.
module tb_vram_write_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hb = 1'b0;
  logic        vb = 1'b0;
  logic        rd_req = 1'b0;
  logic [12:0] rd_addr = '0;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic        wr_valid = 1'b0;
  logic [12:0] wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic        wr_ready;
  logic        clear_start = 1'b0;
  logic        clear_busy;
  logic [4:0]  level;
  logic [12:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_we;
  logic [7:0]  ram_rdata = '0;

  logic [7:0]  mem [8192];
  logic [7:0]  exp_rd = '0;
  logic [20:0] wq [$];
  logic [7:0]  rq [$];
  int          checks = 0;
  int          errors = 0;
  int          rd_cnt = 0;
  int          n;

  vram_write_scheduler dut (
    .i_pix_clk     (clk),
    .i_reset       (rst),
    .i_horz_blank  (hb),
    .i_vert_blank  (vb),
    .i_rd_req      (rd_req),
    .i_rd_addr     (rd_addr),
    .o_rd_valid    (rd_valid),
    .o_rd_data     (rd_data),
    .i_wr_valid    (wr_valid),
    .i_wr_addr     (wr_addr),
    .i_wr_data     (wr_data),
    .o_wr_ready    (wr_ready),
    .i_clear_start (clear_start),
    .o_clear_busy  (clear_busy),
    .o_fifo_level  (level),
    .o_ram_addr    (ram_addr),
    .o_ram_wdata   (ram_wdata),
    .o_ram_we      (ram_we),
    .i_ram_rdata   (ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  always @(posedge clk) begin
    if (!rst && rd_req) rq.push_back(exp_rd);
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (ram_we) begin
        if (wq.size() == 0) begin
          check("unexpected_write", {11'd0, ram_addr, ram_wdata}, 32'hFFFF_FFFF);
        end else begin
          logic [20:0] e;
          e = wq.pop_front();
          check("ram_write", {11'd0, ram_addr, ram_wdata}, {11'd0, e});
        end
      end
      if (rd_valid) begin
        rd_cnt++;
        if (rq.size() == 0) begin
          check("unexpected_rd", {24'd0, rd_data}, 32'hFFFF_FFFF);
        end else begin
          logic [7:0] e;
          e = rq.pop_front();
          check("rd_data", {24'd0, rd_data}, {24'd0, e});
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input logic [12:0] a, input logic [7:0] d);
    wr_addr  = a;
    wr_data  = d;
    wr_valid = 1'b1;
    wq.push_back({a, d});
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic wait_empty(input string name, input int max);
    int k;
    k = 0;
    while (level != 0 && k < max) begin
      tick();
      k++;
    end
    check(name, {27'd0, level}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
    mem[5] = 8'h41;
    mem[6] = 8'h42;
    mem[7] = 8'h43;

    // Reset state
    repeat (3) tick();
    check("rst_we", {31'd0, ram_we}, 32'd0);
    check("rst_ready", {31'd0, wr_ready}, 32'd1);
    check("rst_level", {27'd0, level}, 32'd0);
    check("rst_busy", {31'd0, clear_busy}, 32'd0);
    check("rst_rdv", {31'd0, rd_valid}, 32'd0);
    rst = 1'b0;
    tick();

    // Read latency and burst
    rd_addr = 13'd5; exp_rd = 8'h41; rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    #1;
    check("rd_lat_valid", {31'd0, rd_valid}, 32'd1);
    check("rd_lat_data", {24'd0, rd_data}, 32'h41);
    tick();
    rd_addr = 13'd5; exp_rd = 8'h41; rd_req = 1'b1;
    tick();
    rd_addr = 13'd6; exp_rd = 8'h42;
    tick();
    rd_addr = 13'd7; exp_rd = 8'h43;
    tick();
    rd_req = 1'b0;
    repeat (2) tick();
    check("rd_valid_cycles", rd_cnt, 32'd4);

    // Write gated to blanking
    push_wr(13'd10, 8'h55);
    check("gate_level1", {27'd0, level}, 32'd1);
    repeat (3) begin
      tick();
      #1;
      check("gate_no_we", {31'd0, ram_we}, 32'd0);
    end
    hb = 1'b1;
    #1;
    check("gate_we", {31'd0, ram_we}, 32'd1);
    check("gate_addr", {19'd0, ram_addr}, 32'd10);
    tick();
    check("gate_level0", {27'd0, level}, 32'd0);
    hb = 1'b0;
    tick();

    // Reads stall writes during blanking
    hb = 1'b1;
    rd_addr = 13'd5; exp_rd = 8'h41; rd_req = 1'b1;
    push_wr(13'd20, 8'hA1);
    push_wr(13'd21, 8'hA2);
    push_wr(13'd22, 8'hA3);
    repeat (2) begin
      tick();
      #1;
      check("stall_no_we", {31'd0, ram_we}, 32'd0);
      check("stall_level", {27'd0, level}, 32'd3);
    end
    rd_req = 1'b0;
    wait_empty("stall_drain", 20);
    hb = 1'b0;
    tick();

    // Full FIFO
    for (int i = 0; i < 16; i++) push_wr(13'(100 + i), 8'(i));
    check("full_level", {27'd0, level}, 32'd16);
    check("full_ready", {31'd0, wr_ready}, 32'd0);
    wr_addr = 13'h3E7; wr_data = 8'hFF; wr_valid = 1'b1;
    tick();
    check("full_refuse", {27'd0, level}, 32'd16);
    hb = 1'b1;
    wr_addr = 13'd200; wr_data = 8'hEE;
    tick();
    check("full_pop_refuse", {27'd0, level}, 32'd15);
    wr_valid = 1'b0;
    push_wr(13'd201, 8'hEF);
    check("pushpop_level", {27'd0, level}, 32'd15);
    wait_empty("full_drain", 40);
    tick();

    // Clear fill then queued host write
    clear_start = 1'b1;
    for (int i = 0; i < 8192; i++) wq.push_back({13'(i), 8'h20});
    tick();
    clear_start = 1'b0;
    check("clr_busy", {31'd0, clear_busy}, 32'd1);
    push_wr(13'd3, 8'h7A);
    check("clr_level", {27'd0, level}, 32'd1);
    n = 1;
    while (clear_busy && n < 9000) begin
      tick();
      n++;
    end
    check("clr_cycles", n, 32'd8192);
    wait_empty("clr_drain", 20);
    tick();
    check("clr_mem3", {24'd0, mem[3]}, 32'h7A);
    check("clr_mem8191", {24'd0, mem[8191]}, 32'h20);

    // Reset mid-clear
    clear_start = 1'b1;
    for (int i = 0; i < 10; i++) wq.push_back({13'(i), 8'h20});
    tick();
    clear_start = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    #1;
    check("mid_rst_busy", {31'd0, clear_busy}, 32'd0);
    check("mid_rst_we", {31'd0, ram_we}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("end_wq", wq.size(), 32'd0);
    check("end_rq", rq.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
